// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the cache-side masters, the external word RAM and the port arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface ram_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int NUM_PORTS     = 2
);
    localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]               port_rd;
    logic [NUM_PORTS-1:0]               port_wr;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] port_address;
    logic [NUM_PORTS*32-1:0]            port_data_wr;
    logic [NUM_PORTS-1:0]               port_data_valid;
    logic [31:0]                        port_data_rd;
    logic                               ram_rd;
    logic                               ram_wr;
    logic [ADDRESS_WIDTH-1:0]           ram_address;
    logic [31:0]                        ram_data_wr;
    logic [31:0]                        ram_data_rd;
    logic                               ram_data_valid;
    logic                               arb_busy;
    logic [OW-1:0]                      arb_owner;

    modport slave (
        input  port_rd, port_wr, port_address, port_data_wr, ram_data_rd, ram_data_valid,
        output port_data_valid, port_data_rd, ram_rd, ram_wr, ram_address, ram_data_wr,
               arb_busy, arb_owner
    );

    modport master (
        output port_rd, port_wr, port_address, port_data_wr, ram_data_rd, ram_data_valid,
        input  port_data_valid, port_data_rd, ram_rd, ram_wr, ram_address, ram_data_wr,
               arb_busy, arb_owner
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one word RAM between NUM_PORTS masters, buffering
// command pulses from waiting masters and locking the grant across back-to-back words.
module ram_port_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int NUM_PORTS     = 2,
    parameter int MAX_LOCK_CMDS = 8
) (
    input logic              clk,
    input logic              rst_n,
    ram_port_arbiter_if.slave bus
);
    localparam int AW  = ADDRESS_WIDTH;
    localparam int OW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int LCW = (MAX_LOCK_CMDS > 0) ? $clog2(MAX_LOCK_CMDS + 1) : 1;
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK_CMDS);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

    state_e                 state_q, state_d;
    logic [NUM_PORTS-1:0]   pending_q, pending_d;
    logic [NUM_PORTS-1:0]   pend_wr_q, pend_wr_d;
    logic [AW-1:0]          pend_addr_q [NUM_PORTS];
    logic [AW-1:0]          pend_addr_d [NUM_PORTS];
    logic [31:0]            pend_data_q [NUM_PORTS];
    logic [31:0]            pend_data_d [NUM_PORTS];
    logic [OW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [LCW-1:0]         lock_cnt_q, lock_cnt_d;
    logic                   ram_rd_q, ram_rd_d;
    logic                   ram_wr_q, ram_wr_d;
    logic [AW-1:0]          ram_address_q, ram_address_d;
    logic [31:0]            ram_data_wr_q, ram_data_wr_d;

    logic [NUM_PORTS-1:0]   pulse, req, cmd_wr, consumed;
    logic [AW-1:0]          cmd_addr [NUM_PORTS];
    logic [31:0]            cmd_data [NUM_PORTS];
    logic                   win_found;
    logic [OW-1:0]          winner, cand, rr_next;

    // A live pulse takes priority over the buffered copy; rd+wr together counts as a write.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            pulse[i]    = bus.port_rd[i] | bus.port_wr[i];
            req[i]      = pulse[i] | pending_q[i];
            cmd_wr[i]   = pulse[i] ? bus.port_wr[i] : pend_wr_q[i];
            cmd_addr[i] = pulse[i] ? bus.port_address[i*AW +: AW] : pend_addr_q[i];
            cmd_data[i] = pulse[i] ? bus.port_data_wr[i*32 +: 32] : pend_data_q[i];
        end
    end

    always_comb begin
        win_found = 1'b0;
        winner    = rr_ptr_q;
        cand      = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = OW'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                winner    = cand;
            end
        end
        rr_next = OW'((int'(owner_q) + 1) % NUM_PORTS);
    end

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        pend_wr_d     = pend_wr_q;
        pend_addr_d   = pend_addr_q;
        pend_data_d   = pend_data_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        lock_cnt_d    = lock_cnt_q;
        ram_rd_d      = 1'b0;
        ram_wr_d      = 1'b0;
        ram_address_d = ram_address_q;
        ram_data_wr_d = ram_data_wr_q;
        consumed      = '0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    ram_wr_d         = cmd_wr[winner];
                    ram_rd_d         = ~cmd_wr[winner];
                    ram_address_d    = cmd_addr[winner];
                    ram_data_wr_d    = cmd_data[winner];
                    owner_d          = winner;
                    lock_cnt_d       = LCW'(1);
                    consumed[winner] = 1'b1;
                    state_d          = WAIT;
                end
            end
            WAIT: begin
                if (bus.ram_data_valid) state_d = HOLD;
            end
            HOLD: begin
                if (req[owner_q] && ((MAX_LOCK_CMDS == 0) || (lock_cnt_q < LOCK_MAX))) begin
                    ram_wr_d          = cmd_wr[owner_q];
                    ram_rd_d          = ~cmd_wr[owner_q];
                    ram_address_d     = cmd_addr[owner_q];
                    ram_data_wr_d     = cmd_data[owner_q];
                    consumed[owner_q] = 1'b1;
                    if (MAX_LOCK_CMDS != 0) lock_cnt_d = lock_cnt_q + LCW'(1);
                    state_d           = WAIT;
                end else begin
                    rr_ptr_d = rr_next;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Anything not issued this cycle is remembered until the RAM frees up.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (consumed[i]) begin
                pending_d[i] = 1'b0;
            end else if (pulse[i]) begin
                pending_d[i]   = 1'b1;
                pend_wr_d[i]   = bus.port_wr[i];
                pend_addr_d[i] = bus.port_address[i*AW +: AW];
                pend_data_d[i] = bus.port_data_wr[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            pend_wr_q     <= '0;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            lock_cnt_q    <= '0;
            ram_rd_q      <= 1'b0;
            ram_wr_q      <= 1'b0;
            ram_address_q <= '0;
            ram_data_wr_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                pend_addr_q[i] <= '0;
                pend_data_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            pend_wr_q     <= pend_wr_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            lock_cnt_q    <= lock_cnt_d;
            ram_rd_q      <= ram_rd_d;
            ram_wr_q      <= ram_wr_d;
            ram_address_q <= ram_address_d;
            ram_data_wr_q <= ram_data_wr_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                pend_addr_q[i] <= pend_addr_d[i];
                pend_data_q[i] <= pend_data_d[i];
            end
        end
    end

    // Responses only route while a command is outstanding; valids in IDLE/HOLD are dropped.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            bus.port_data_valid[i] = bus.ram_data_valid && (state_q == WAIT) && (owner_q == OW'(i));
        end
    end

    assign bus.port_data_rd = bus.ram_data_rd;
    assign bus.ram_rd       = ram_rd_q;
    assign bus.ram_wr       = ram_wr_q;
    assign bus.ram_address  = ram_address_q;
    assign bus.ram_data_wr  = ram_data_wr_q;
    assign bus.arb_busy     = (state_q != IDLE);
    assign bus.arb_owner    = owner_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a default-lock DUT (index 0) and a MAX_LOCK_CMDS=4 DUT
// (index 1) share stimulus tasks; a RAM responder answers each command two cycles later.
module tb_ram_port_arbiter;
    localparam int AW = 16;
    localparam int NP = 2;
    localparam int OW = $clog2(NP);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    typedef struct { int d; int port; bit wr; logic [AW-1:0] addr; logic [31:0] data; } cmd_t;
    typedef struct { int d; logic [NP-1:0] mask; logic [31:0] data; } rsp_t;

    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];
    int   checks   = 0;
    int   failures = 0;
    bit   auto_resp = 1'b1;

    logic [NP-1:0]    p_rd    [2];
    logic [NP-1:0]    p_wr    [2];
    logic [NP*AW-1:0] p_addr  [2];
    logic [NP*32-1:0] p_wdata [2];
    logic             r_valid [2];
    logic [31:0]      r_rdata [2];

    logic             o_rd    [2];
    logic             o_wr    [2];
    logic [AW-1:0]    o_addr  [2];
    logic [31:0]      o_wdata [2];
    logic [NP-1:0]    o_pdv   [2];
    logic [31:0]      o_prd   [2];
    logic             o_busy  [2];
    logic [OW-1:0]    o_owner [2];

    ram_port_arbiter_if #(.ADDRESS_WIDTH(AW), .NUM_PORTS(NP)) bus0 ();
    ram_port_arbiter_if #(.ADDRESS_WIDTH(AW), .NUM_PORTS(NP)) bus1 ();

    assign bus0.port_rd = p_rd[0];        assign bus1.port_rd = p_rd[1];
    assign bus0.port_wr = p_wr[0];        assign bus1.port_wr = p_wr[1];
    assign bus0.port_address = p_addr[0]; assign bus1.port_address = p_addr[1];
    assign bus0.port_data_wr = p_wdata[0]; assign bus1.port_data_wr = p_wdata[1];
    assign bus0.ram_data_valid = r_valid[0]; assign bus1.ram_data_valid = r_valid[1];
    assign bus0.ram_data_rd = r_rdata[0]; assign bus1.ram_data_rd = r_rdata[1];

    assign o_rd[0] = bus0.ram_rd;          assign o_rd[1] = bus1.ram_rd;
    assign o_wr[0] = bus0.ram_wr;          assign o_wr[1] = bus1.ram_wr;
    assign o_addr[0] = bus0.ram_address;   assign o_addr[1] = bus1.ram_address;
    assign o_wdata[0] = bus0.ram_data_wr;  assign o_wdata[1] = bus1.ram_data_wr;
    assign o_pdv[0] = bus0.port_data_valid; assign o_pdv[1] = bus1.port_data_valid;
    assign o_prd[0] = bus0.port_data_rd;   assign o_prd[1] = bus1.port_data_rd;
    assign o_busy[0] = bus0.arb_busy;      assign o_busy[1] = bus1.arb_busy;
    assign o_owner[0] = bus0.arb_owner;    assign o_owner[1] = bus1.arb_owner;

    ram_port_arbiter #(.ADDRESS_WIDTH(AW), .NUM_PORTS(NP), .MAX_LOCK_CMDS(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    ram_port_arbiter #(.ADDRESS_WIDTH(AW), .NUM_PORTS(NP), .MAX_LOCK_CMDS(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
        return (a == 16'h0040) ? 32'hDEADBEEF : {16'hC0DE, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cmd(input int d, input int p, input bit wr, input logic [AW-1:0] a,
                           input logic [31:0] dat);
        if (wr) p_wr[d][p] = 1'b1; else p_rd[d][p] = 1'b1;
        p_addr[d][p*AW +: AW]  = a;
        p_wdata[d][p*32 +: 32] = dat;
    endtask

    task automatic clr_cmd(input int d, input int p);
        p_rd[d][p] = 1'b0;
        p_wr[d][p] = 1'b0;
    endtask

    task automatic pulse(input int d, input int p, input bit wr, input logic [AW-1:0] a,
                         input logic [31:0] dat);
        set_cmd(d, p, wr, a, dat);
        @(posedge clk); #1;
        clr_cmd(d, p);
    endtask

    task automatic expect_cmd(input int d, input int p, input bit wr, input logic [AW-1:0] a,
                              input logic [31:0] dat, input bit with_rsp);
        cmd_t c;
        rsp_t r;
        c.d = d; c.port = p; c.wr = wr; c.addr = a; c.data = dat;
        exp_cmd.push_back(c);
        if (with_rsp) begin
            r.d = d; r.mask = NP'(1) << p; r.data = ram_word(a);
            exp_rsp.push_back(r);
        end
    endtask

    task automatic wait_valid(input int d, input int p);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (o_pdv[d][p]) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_valid dut%0d port%0d: got no response expected one within 300 cycles", d, p);
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && (exp_cmd.size() != 0 || exp_rsp.size() != 0); n++) @(negedge clk);
        chk("drain_outstanding", 64'(exp_cmd.size() + exp_rsp.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            p_rd[d] = '0; p_wr[d] = '0; r_valid[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic responder(input int d);
        logic [AW-1:0] a;
        forever begin
            @(negedge clk);
            if (auto_resp && rst_n && (o_rd[d] || o_wr[d])) begin
                a = o_addr[d];
                repeat (2) @(posedge clk);
                #1;
                r_rdata[d] = ram_word(a);
                r_valid[d] = 1'b1;
                @(posedge clk); #1;
                r_valid[d] = 1'b0;
            end
        end
    endtask

    // Monitor: every RAM command and every port response is matched against the queues.
    initial begin
        cmd_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    if (o_rd[d] || o_wr[d]) begin
                        if (exp_cmd.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL unexpected_cmd dut%0d: got rd=%0d wr=%0d addr=%0h expected none",
                                     d, o_rd[d], o_wr[d], o_addr[d]);
                        end else begin
                            e = exp_cmd.pop_front();
                            chk("cmd_dut", 64'(d), 64'(e.d));
                            chk("cmd_owner", 64'(o_owner[d]), 64'(e.port));
                            chk("cmd_wr", 64'(o_wr[d]), 64'(e.wr));
                            chk("cmd_rd", 64'(o_rd[d]), 64'(!e.wr));
                            chk("cmd_addr", 64'(o_addr[d]), 64'(e.addr));
                            if (e.wr) chk("cmd_wdata", 64'(o_wdata[d]), 64'(e.data));
                        end
                    end
                    if (o_pdv[d] != '0) begin
                        if (exp_rsp.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL unexpected_rsp dut%0d: got valid=%0b expected none", d, o_pdv[d]);
                        end else begin
                            r = exp_rsp.pop_front();
                            chk("rsp_dut", 64'(d), 64'(r.d));
                            chk("rsp_mask", 64'(o_pdv[d]), 64'(r.mask));
                            chk("rsp_data", 64'(o_prd[d]), 64'(r.data));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic burst(input int d);
        // Port0: 4-word writeback then 4-word fetch; port1 pulses alongside command 2.
        for (int k = 0; k < 8; k++) begin
            if (d == 1 && k == 4) expect_cmd(d, 1, 1'b0, 16'h4000, 32'h0, 1'b1);
            expect_cmd(d, 0, k < 4, AW'(16'h3000 + k * 4), 32'hB000_0000 | k, 1'b1);
        end
        if (d == 0) expect_cmd(d, 1, 1'b0, 16'h4000, 32'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 1) set_cmd(d, 1, 1'b0, 16'h4000, 32'h0);
            pulse(d, 0, k < 4, AW'(16'h3000 + k * 4), 32'hB000_0000 | k);
            clr_cmd(d, 1);
            wait_valid(d, 0);
            @(posedge clk); #1;
        end
        drain();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            p_rd[d] = '0; p_wr[d] = '0; p_addr[d] = '0; p_wdata[d] = '0;
            r_valid[d] = 1'b0; r_rdata[d] = '0;
        end
        fork
            responder(0);
            responder(1);
        join_none
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ram_rd", 64'(o_rd[d]), 64'd0);
            chk("reset_ram_wr", 64'(o_wr[d]), 64'd0);
            chk("reset_ram_addr", 64'(o_addr[d]), 64'd0);
            chk("reset_ram_wdata", 64'(o_wdata[d]), 64'd0);
            chk("reset_pdv", 64'(o_pdv[d]), 64'd0);
            chk("reset_busy", 64'(o_busy[d]), 64'd0);
            chk("reset_owner", 64'(o_owner[d]), 64'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // T1 single read
        expect_cmd(0, 0, 1'b0, 16'h0040, 32'h0, 1'b1);
        pulse(0, 0, 1'b0, 16'h0040, 32'h0);
        @(negedge clk);
        chk("t1_ram_rd_t+1", 64'(o_rd[0]), 64'd1);
        chk("t1_ram_addr", 64'(o_addr[0]), 64'h0040);
        chk("t1_busy", 64'(o_busy[0]), 64'd1);
        @(negedge clk);
        chk("t1_ram_rd_one_cycle", 64'(o_rd[0]), 64'd0);
        wait_valid(0, 0);
        chk("t1_port_data_rd", 64'(o_prd[0]), 64'hDEADBEEF);
        chk("t1_port_data_valid", 64'(o_pdv[0]), 64'b01);
        drain();

        // T2 simultaneous read/write with rr_ptr = 0
        do_reset();
        expect_cmd(0, 0, 1'b0, 16'h0100, 32'h0, 1'b1);
        expect_cmd(0, 1, 1'b1, 16'h0200, 32'h12345678, 1'b1);
        set_cmd(0, 0, 1'b0, 16'h0100, 32'h0);
        set_cmd(0, 1, 1'b1, 16'h0200, 32'h12345678);
        @(posedge clk); #1;
        clr_cmd(0, 0); clr_cmd(0, 1);
        wait_valid(0, 0);
        repeat (2) begin
            @(negedge clk);
            chk("t2_gap_no_cmd", 64'(o_rd[0] | o_wr[0]), 64'd0);
        end
        @(negedge clk);
        chk("t2_ram_wr", 64'(o_wr[0]), 64'd1);
        chk("t2_ram_data_wr", 64'(o_wdata[0]), 64'h12345678);
        drain();

        // T3 burst lock: unlimited-within-8 on dut0, forced release at 4 on dut1
        do_reset();
        burst(0);
        do_reset();
        burst(1);

        // T4 fairness; masters re-pulse once the grant has been released
        do_reset();
        for (int k = 0; k < 3; k++) begin
            expect_cmd(0, 0, 1'b0, AW'(16'h1000 + k), 32'h0, 1'b1);
            expect_cmd(0, 1, 1'b0, AW'(16'h2000 + k), 32'h0, 1'b1);
        end
        fork
            for (int k = 0; k < 3; k++) begin
                pulse(0, 0, 1'b0, AW'(16'h1000 + k), 32'h0);
                wait_valid(0, 0);
                repeat (2) begin @(posedge clk); #1; end
            end
            for (int j = 0; j < 3; j++) begin
                pulse(0, 1, 1'b0, AW'(16'h2000 + j), 32'h0);
                wait_valid(0, 1);
                repeat (2) begin @(posedge clk); #1; end
            end
        join
        drain();

        // T5 reset while waiting with port1 pending
        do_reset();
        auto_resp = 1'b0;
        expect_cmd(0, 0, 1'b0, 16'h5000, 32'h0, 1'b0);
        set_cmd(0, 0, 1'b0, 16'h5000, 32'h0);
        set_cmd(0, 1, 1'b0, 16'h5100, 32'h0);
        @(posedge clk); #1;
        clr_cmd(0, 0); clr_cmd(0, 1);
        @(negedge clk);
        chk("t5_busy_before", 64'(o_busy[0]), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ram_rd", 64'(o_rd[0]), 64'd0);
        chk("t5_rst_ram_wr", 64'(o_wr[0]), 64'd0);
        chk("t5_rst_ram_addr", 64'(o_addr[0]), 64'd0);
        chk("t5_rst_pdv", 64'(o_pdv[0]), 64'd0);
        chk("t5_rst_busy", 64'(o_busy[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        r_rdata[0] = 32'hFFFF0000;
        r_valid[0] = 1'b1;
        @(negedge clk);
        chk("t5_late_valid_pdv", 64'(o_pdv[0]), 64'd0);
        @(posedge clk); #1;
        r_valid[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_busy_after", 64'(o_busy[0]), 64'd0);
        drain();

        // T6 stray valid in IDLE
        @(posedge clk); #1;
        r_valid[0] = 1'b1;
        @(negedge clk);
        chk("t6_stray_pdv", 64'(o_pdv[0]), 64'd0);
        chk("t6_stray_busy", 64'(o_busy[0]), 64'd0);
        @(posedge clk); #1;
        r_valid[0] = 1'b0;
        @(negedge clk);
        chk("t6_still_idle", 64'(o_busy[0]), 64'd0);
        auto_resp = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
